uut_result_packer: RTL and testbench

UUT_RESULT_PACKER -- requirements
Module: uut_result_packer

---
 rtl/uut_result_packer.sv | 127 ++++++++++++
 tb/tb_uut_result_packer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uut_result_packer.sv
// uut_result_packer: runs one UUT measurement per start pulse, packs each result
// into a 32-byte big-endian record, and presents a 512-byte block for bytewise
// readout once the block is full or flushed.
module uut_result_packer #(
    parameter logic [31:0] TIMEOUT = 32'd1000000,
    parameter int          RECORDS = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         flush,
    input  logic [63:0]  plaintext_i,
    output logic [63:0]  plaintext_uut,
    output logic         rst_uut,
    input  logic [127:0] hash_i,
    input  logic         end_i,
    output logic         busy,
    output logic         block_ready,
    input  logic         byte_rd,
    output logic [7:0]   byte_o,
    output logic [4:0]   rec_count
);

    typedef enum logic [1:0] {IDLE, RUN, STORE, READOUT} state_t;

    state_t        state;
    logic [31:0]   cycle_cnt;
    logic [31:0]   seq;
    logic [8:0]    rd_ptr;
    logic [31:0]   cap_count;
    logic [127:0]  cap_hash;
    logic [255:0]  rec_mem [16];
    logic [3:0]    rd_slot;

    // Pick byte idx (0 = most significant) out of a packed big-endian record.
    function automatic logic [7:0] rec_byte(input logic [255:0] rec, input logic [4:0] idx);
        int sh;
        sh = 8 * (31 - int'(idx));
        return rec[sh +: 8];
    endfunction

    // Status outputs are straight decodes of the state register.
    assign busy        = (state != IDLE);
    assign block_ready = (state == READOUT);
    assign rst_uut     = (state == IDLE);
    assign rd_slot     = rd_ptr[8:5];

    // Control FSM: measurement sequencing, record/seq bookkeeping, read pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cycle_cnt     <= 32'd0;
            seq           <= 32'd0;
            rd_ptr        <= 9'd0;
            rec_count     <= 5'd0;
            plaintext_uut <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    // A useful flush takes priority; an empty flush lets start through.
                    if (flush && rec_count != 5'd0) begin
                        rd_ptr <= 9'd0;
                        state  <= READOUT;
                    end else if (start) begin
                        plaintext_uut <= plaintext_i;
                        cycle_cnt     <= 32'd0;
                        state         <= RUN;
                    end
                end
                RUN: begin
                    if (end_i || cycle_cnt == TIMEOUT - 32'd1) begin
                        state <= STORE;
                    end else begin
                        cycle_cnt <= cycle_cnt + 32'd1;
                    end
                end
                STORE: begin
                    rec_count <= rec_count + 5'd1;
                    seq       <= seq + 32'd1;
                    if (rec_count + 5'd1 == 5'(RECORDS)) begin
                        rd_ptr <= 9'd0;
                        state  <= READOUT;
                    end else begin
                        state <= IDLE;
                    end
                end
                READOUT: begin
                    if (byte_rd) begin
                        if (rd_ptr == 9'd511) begin
                            rd_ptr    <= 9'd0;
                            rec_count <= 5'd0;
                            state     <= IDLE;
                        end else begin
                            rd_ptr <= rd_ptr + 9'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Result capture and record buffer; data only, stale slots are masked on read.
    always_ff @(posedge clk) begin
        if (state == RUN) begin
            if (end_i) begin
                cap_count <= cycle_cnt;
                cap_hash  <= hash_i;
            end else if (cycle_cnt == TIMEOUT - 32'd1) begin
                cap_count <= 32'hFFFF_FFFF;
                cap_hash  <= 128'd0;
            end
        end
        if (state == STORE) begin
            rec_mem[rec_count[3:0]] <= {seq, cap_count, plaintext_uut, cap_hash};
        end
    end

    // Byte at the read pointer; slots not yet written this block read as zero.
    always_comb begin
        byte_o = 8'h00;
        if ({1'b0, rd_slot} < rec_count) begin
            byte_o = rec_byte(rec_mem[rd_slot], rd_ptr[4:0]);
        end
    end

endmodule

// File: tb/tb_uut_result_packer.sv
// Randomized scoreboard bench for uut_result_packer.
module tb_uut_result_packer;

    localparam int TO_P  = 40;
    localparam int REC_P = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [63:0]  plaintext_i = '0;
    logic [63:0]  plaintext_uut;
    logic         rst_uut;
    logic [127:0] hash_i = '0;
    logic         end_i = 1'b0;
    logic         busy;
    logic         block_ready;
    logic         byte_rd = 1'b0;
    logic [7:0]   byte_o;
    logic [4:0]   rec_count;

    uut_result_packer #(.TIMEOUT(32'(TO_P)), .RECORDS(REC_P)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .plaintext_i(plaintext_i), .plaintext_uut(plaintext_uut), .rst_uut(rst_uut),
        .hash_i(hash_i), .end_i(end_i), .busy(busy), .block_ready(block_ready),
        .byte_rd(byte_rd), .byte_o(byte_o), .rec_count(rec_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  seq;
        logic [31:0]  count;
        logic [63:0]  pt;
        logic [127:0] hash;
    } rec_t;

    rec_t        rec_q[$];
    logic [7:0]  exp_q[$];
    logic [31:0] model_seq = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_byte = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: byte i of the block from the list of stored records.
    function automatic logic [7:0] model_byte(input int i);
        int k, b;
        rec_t r;
        k = i / 32;
        b = i % 32;
        if (k >= rec_q.size()) return 8'h00;
        r = rec_q[k];
        if (b < 4)  return 8'(r.seq   >> (8 * (3 - b)));
        if (b < 8)  return 8'(r.count >> (8 * (7 - b)));
        if (b < 16) return 8'(r.pt    >> (8 * (15 - b)));
        return 8'(r.hash >> (8 * (31 - b)));
    endfunction

    // Monitor: every consumed byte during readout is checked against the queue.
    always @(negedge clk) begin
        if (rst && byte_rd && block_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_byte", 1'b1, 1'b0);
            end else begin
                check($sformatf("byte_%0d", n_byte), byte_o, exp_q.pop_front());
            end
            n_byte++;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_block_ready", block_ready, 0);
        check("rst_rec_count", rec_count, 0);
        check("rst_rst_uut", rst_uut, 1);
        check("rst_plaintext_uut", plaintext_uut, 0);
        check("rst_byte_o", byte_o, 0);
        rec_q.delete();
        exp_q.delete();
        model_seq = 0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    // One measurement: end_i raised after d low RUN cycles (d >= TO_P means timeout).
    task automatic meas(input logic [63:0] pt, input int d, input bit poke);
        logic [127:0] h;
        rec_t r;
        bit full;
        h = {$urandom, $urandom, $urandom, $urandom};
        plaintext_i = pt;
        hash_i = h;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        plaintext_i = {$urandom, $urandom};
        check("run_rst_uut", rst_uut, 0);
        check("run_plaintext_uut", plaintext_uut, pt);
        if (d < TO_P) begin
            for (int i = 0; i < d; i++) begin
                if (poke && i == 1) start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            end_i = 1'b1;
            @(posedge clk); #1;
            end_i = 1'b0;
        end
        r.seq = model_seq;
        r.count = (d < TO_P) ? 32'(d) : 32'hFFFF_FFFF;
        r.pt = pt;
        r.hash = (d < TO_P) ? h : 128'd0;
        rec_q.push_back(r);
        model_seq++;
        full = (rec_q.size() == REC_P);
        for (int n = 0; n < TO_P + 20; n++) begin
            if (full ? block_ready : !busy) break;
            @(posedge clk); #1;
        end
        if (full) check("auto_block_ready", block_ready, 1);
        else      check("meas_idle", busy, 0);
        check("meas_rec_count", rec_count, full ? 5'd16 : 5'(rec_q.size()));
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_block_ready", block_ready, 1);
    endtask

    // Consume n bytes; optionally pulse start alongside byte poke_at.
    task automatic readout(input int n, input int poke_at);
        n_byte = 0;
        for (int i = 0; i < n; i++) exp_q.push_back(model_byte(i));
        for (int i = 0; i < n; i++) begin
            byte_rd = 1'b1;
            start = (i == poke_at);
            @(posedge clk); #1;
            byte_rd = 1'b0;
            start = 1'b0;
        end
        if (n == 512) begin
            rec_q.delete();
            check("ro_busy", busy, 0);
            check("ro_block_ready", block_ready, 0);
            check("ro_rec_count", rec_count, 0);
        end
    endtask

    initial begin
        do_reset();

        // Known-vector single record, partial block via flush.
        meas(64'h0123456789ABCDEF, 31, 1'b0);
        do_flush();
        readout(512, -1);

        // Empty flush ignored; byte_rd in IDLE ignored.
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("empty_flush_busy", busy, 0);
        meas({$urandom, $urandom}, 0, 1'b0);
        byte_rd = 1'b1;
        @(posedge clk); #1;
        byte_rd = 1'b0;
        check("idle_byte_rd_busy", busy, 0);
        check("idle_byte_rd_count", rec_count, 1);
        do_flush();
        readout(512, -1);

        // Full block from a clean reset, including timeouts and ignored starts.
        do_reset();
        for (int k = 0; k < REC_P; k++) begin
            int d;
            d = (k == 3) ? TO_P + 5 : (k == 7) ? TO_P - 1 : int'($urandom_range(0, 45));
            meas({$urandom, $urandom}, d, k == 5);
        end
        readout(512, 200);
        meas({$urandom, $urandom}, int'($urandom_range(2, 20)), 1'b0);
        meas({$urandom, $urandom}, TO_P + 3, 1'b0);
        do_flush();
        readout(512, -1);

        // Reset in the middle of readout discards the block.
        meas({$urandom, $urandom}, 4, 1'b0);
        do_flush();
        readout(100, -1);
        do_reset();
        meas({$urandom, $urandom}, int'($urandom_range(0, 30)), 1'b0);
        do_flush();
        readout(512, -1);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
